uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Next-generation UART transmitter: parametrised data width, stop-bit count and baud divisor.
//  An internal TX FIFO accepts back-to-back trmt requests. Frames are sent gap-free while data remains.
//  Sits between the command/response logic and the serial pin. Pairs with the existing UART receiver.
// PARAMETERS
//  DATA_W      8     payload bits per frame (5..9), sent LSB first
//  BAUD_DIV    2604  clk cycles per bit (12'hA2C); legal range 4..4095
//  STOP_BITS   1     stop bits per frame (1 or 2)
//  FIFO_DEPTH  4     TX FIFO entries; power of 2, >= 2
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst         in   1       synchronous, active-high reset
//  trmt        in   1       push request; tx_data captured this edge if !tx_full
//  tx_data     in   DATA_W  payload to queue
//  parity_odd  in   1       0=even, 1=odd parity (port exists only with UART_TX_PARITY_EN)
//  tx_full     out  1       FIFO holds FIFO_DEPTH entries
//  tx_ovr      out  1       1-cycle pulse: trmt while full and no pop that cycle; data dropped
//  busy        out  1       frame in progress (state != IDLE)
//  tx_done     out  1       1-cycle pulse after last stop bit of every frame
//  TX          out  1       serial line, registered, idle high
// BEHAVIOUR
//  Reset: TX=1, busy=0, tx_done=0, tx_ovr=0, tx_full=0, FIFO emptied, baud/bit counters=0, state=IDLE.
//  Reset mid-frame: frame aborted. TX=1 on the reset edge. Queued data lost.
//  FIFO: push on trmt & !tx_full. Push while full is accepted only if a pop occurs in the same cycle.
//   Push into empty FIFO while IDLE: the FSM pops on the following edge.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE | START.
//   IDLE:   if FIFO not empty: pop into shift reg, TX<=0, baud_cnt<=BAUD_DIV-1, go START.
//   START:  when baud_cnt==0: TX<=shift[0], bit_cnt<=0, go DATA.
//   DATA:   each baud_cnt==0: shift right, bit_cnt++. After bit DATA_W-1 go PARITY/STOP, TX set accordingly.
//   PARITY: TX = ^payload ^ parity_odd (parity_odd sampled at pop). One bit time, then STOP.
//   STOP:   TX=1 for STOP_BITS bit times. At the end tx_done=1 for one cycle.
//           If FIFO not empty: pop and enter START on that same edge (no idle gap), else IDLE.
//  Latency: trmt sampled at edge N with FIFO empty and IDLE -> TX falls at edge N+2.
//  Every bit lasts exactly BAUD_DIV clk. Frame = BAUD_DIV*(1+DATA_W+P+STOP_BITS) clk, P=1 if parity on.
//  baud_cnt reloads BAUD_DIV-1 at each bit boundary. bit_cnt width = $clog2(DATA_W+1).
//  tx_data, parity_odd are don't-care except when trmt (resp. pop) is active.
// CONFIGURATION
//  `UART_TX_PARITY_EN defined: parity_odd port and PARITY state exist; frame has 1 parity bit.
//  Undefined: no parity_odd port, no PARITY state; DATA goes straight to STOP (8N1 for defaults).
// STRUCTURE
//  Package uart_pkg: tx_state_t enum (IDLE, START, DATA, PARITY, STOP), BAUD_W=12, default BAUD_DIV constant.
//  Sub-module uart_sync_fifo (DATA_W+1 wide incl. parity_odd, FIFO_DEPTH deep, full/empty, ptr wrap).
//  FSM + baud/bit counters + shift reg live in uart_tx_fifo.
// TESTING (bench uses BAUD_DIV=16, DATA_W=8, STOP_BITS=1 unless stated)
//  1 single byte: trmt 8'h6A -> TX low at N+2, bits 0,1,0,1,0,1,1,0 each 16 clk, stop high, tx_done after 160 clk.
//  2 burst: 4 trmt back-to-back (8'h01,8'h80,8'hFF,8'h00) -> 4 contiguous frames, no idle gap, 4 tx_done pulses.
//  3 overflow: 6 trmt back-to-back while first frame starting -> tx_full asserted, tx_ovr pulse on the 6th, 5 frames sent.
//  4 parity (macro on): 8'h6A odd -> parity bit 1; 8'h6A even -> 0; frame 176 clk.
//  5 reset mid-frame: rst during DATA bit 3 -> TX=1 next edge, busy=0, no tx_done, FIFO empty, next trmt frames cleanly.
//  6 DATA_W=7, STOP_BITS=2: trmt 7'h55 -> 7 data bits, stop high 32 clk, tx_done at 160 clk.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   BAUD_W        width of the baud down-counter (max divisor 4095)
//   BAUD_DIV_DEF  default clocks per bit (12'hA2C)
//   tx_state_t    transmitter FSM encoding; PARITY exists only when
//                 UART_TX_PARITY_EN is defined
package uart_pkg;

  localparam int BAUD_W = 12;
  localparam logic [BAUD_W-1:0] BAUD_DIV_DEF = 12'hA2C;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; holds queued TX payloads.
//   clk, rst  clock / synchronous active-high reset (empties the FIFO)
//   push      write request; accepted when not full, or when full and a pop
//             happens in the same cycle
//   pop       read request; ignored while empty
//   wdata     entry to write
//   rdata     head entry (combinational, valid while !empty)
//   full      DEPTH entries held
//   empty     no entries held
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal TX FIFO; sends queued frames gap-free.
// Optional parity: define UART_TX_PARITY_EN to add the parity_odd port and a
// parity bit after the data bits.
//   clk         system clock
//   rst         synchronous active-high reset; aborts any frame, drops queue
//   trmt        push request, tx_data captured when accepted
//   tx_data     payload, sent LSB first
//   parity_odd  0 = even, 1 = odd parity (UART_TX_PARITY_EN only)
//   tx_full     FIFO holds FIFO_DEPTH entries
//   tx_ovr      1-cycle pulse: trmt dropped because FIFO full and no pop
//   busy        FSM not IDLE
//   tx_done     1-cycle pulse as the last stop bit of each frame ends on TX
//   TX          registered serial line, idle high
module uart_tx_fifo import uart_pkg::*; #(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = int'(BAUD_DIV_DEF),
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trmt,
  input  logic [DATA_W-1:0] tx_data,
`ifdef UART_TX_PARITY_EN
  input  logic              parity_odd,
`endif
  output logic              tx_full,
  output logic              tx_ovr,
  output logic              busy,
  output logic              tx_done,
  output logic              TX
);

`ifdef UART_TX_PARITY_EN
  localparam int FW = DATA_W + 1;
`else
  localparam int FW = DATA_W;
`endif
  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_RLD  = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BCW-1:0]    LAST_DATA = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0]    LAST_STOP = BCW'(STOP_BITS - 1);

  tx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              line;
  logic              done_int;
  logic [FW-1:0]     fifo_wdata;
  logic [FW-1:0]     fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              bit_end;
  logic              stop_end;
  logic              pop;

`ifdef UART_TX_PARITY_EN
  logic par_bit;
  assign fifo_wdata = {parity_odd, tx_data};
`else
  assign fifo_wdata = tx_data;
`endif

  assign bit_end  = (baud_cnt == '0);
  assign stop_end = (state == STOP) && bit_end && (bit_cnt == LAST_STOP);
  // Pop from IDLE, or at the very end of the stop bits so the next start bit
  // follows without an idle gap.
  assign pop      = !fifo_empty && ((state == IDLE) || stop_end);

  uart_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (trmt),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_full = fifo_full;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      line     <= 1'b1;
      done_int <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      done_int <= 1'b0;
      if (state != IDLE && !bit_end) baud_cnt <= baud_cnt - BAUD_W'(1);

      case (state)
        IDLE: ;
        START: if (bit_end) begin
          line     <= shift[0];
          bit_cnt  <= '0;
          baud_cnt <= BAUD_RLD;
          state    <= DATA;
        end
        DATA: if (bit_end) begin
          baud_cnt <= BAUD_RLD;
          if (bit_cnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
            line  <= par_bit;
            state <= PARITY;
`else
            line    <= 1'b1;
            bit_cnt <= '0;
            state   <= STOP;
`endif
          end else begin
            shift   <= shift >> 1;
            line    <= shift[1];
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          line     <= 1'b1;
          bit_cnt  <= '0;
          baud_cnt <= BAUD_RLD;
          state    <= STOP;
        end
`endif
        STOP: if (bit_end) begin
          if (bit_cnt == LAST_STOP) begin
            done_int <= 1'b1;
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            bit_cnt  <= bit_cnt + BCW'(1);
            baud_cnt <= BAUD_RLD;
          end
        end
        default: state <= IDLE;
      endcase

      // Loading a new frame overrides the IDLE/STOP outcome above.
      if (pop) begin
        shift    <= fifo_rdata[DATA_W-1:0];
`ifdef UART_TX_PARITY_EN
        par_bit  <= (^fifo_rdata[DATA_W-1:0]) ^ fifo_rdata[DATA_W];
`endif
        line     <= 1'b0;
        baud_cnt <= BAUD_RLD;
        state    <= START;
      end
    end
  end

  // Output stage: the pin and tx_done are retimed from the FSM's line value,
  // so TX falls two edges after trmt and tx_done lines up with the end of the
  // stop bit on the pin. Every bit is delayed equally, so widths are exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      TX      <= 1'b1;
      tx_done <= 1'b0;
      tx_ovr  <= 1'b0;
    end else begin
      TX      <= line;
      tx_done <= done_int;
      tx_ovr  <= trmt && fifo_full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int BD = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Both DUT configs (8N1 / 7N2, or with parity 8P1 / 7P2) use NB bit times.
  localparam int FB = BD * NB;

  typedef struct { logic [7:0] data; logic odd; logic [10:0] exp; } vec_t;
  typedef struct { logic [7:0] data; logic odd; } push_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trmt = 1'b0, trmt7 = 1'b0, par_odd = 1'b0;
  logic [7:0] tx_data = '0;
  logic [6:0] tx_data7 = '0;
  logic tx_full, tx_ovr, busy, tx_done, TX;
  logic tx_full7, tx_ovr7, busy7, tx_done7, TX7;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  push_t pushq[$];
  bit    expq[$];
  int    exp_done[$];
  vec_t  vt[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.DATA_W(8), .BAUD_DIV(BD), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .trmt(trmt), .tx_data(tx_data),
`ifdef UART_TX_PARITY_EN
    .parity_odd(par_odd),
`endif
    .tx_full(tx_full), .tx_ovr(tx_ovr), .busy(busy), .tx_done(tx_done), .TX(TX)
  );

  uart_tx_fifo #(.DATA_W(7), .BAUD_DIV(BD), .STOP_BITS(2), .FIFO_DEPTH(4)) dut7 (
    .clk(clk), .rst(rst), .trmt(trmt7), .tx_data(tx_data7),
`ifdef UART_TX_PARITY_EN
    .parity_odd(par_odd),
`endif
    .tx_full(tx_full7), .tx_ovr(tx_ovr7), .busy(busy7), .tx_done(tx_done7), .TX(TX7)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    pushq.delete();
    expq.delete();
    exp_done.delete();
  endtask

  // Queue one trmt; if accepted, queue its expected bit stream and tx_done time
  // (relative to the first push edge: frame k ends at 2 + FB*(k+1)).
  task automatic add_frame(input vec_t v, input bit accepted);
    push_t p;
    p.data = v.data;
    p.odd  = v.odd;
    pushq.push_back(p);
    if (accepted) begin
      for (int k = 0; k < NB; k++) expq.push_back(v.exp[k]);
      exp_done.push_back(2 + FB * (exp_done.size() + 1));
    end
  endtask

  // Drive the queued pushes back-to-back, then watch the line for span cycles.
  task automatic watch(input string tag, input bit d7, input int span,
                       input int exp_ovr, output int first_full);
    int n0, rel, r, idx, nd, nov, nfr;
    logic tx_s, done_s, busy_s, ovr_s, full_s;
    push_t p;
    idx = 0; nd = 0; nov = 0; first_full = -1;
    nfr = exp_done.size();
    n0 = cyc + 1;
    for (int t = 0; t < span; t++) begin
      if (pushq.size() > 0) begin
        p = pushq.pop_front();
        trmt = !d7; trmt7 = d7;
        tx_data = p.data; tx_data7 = p.data[6:0]; par_odd = p.odd;
      end else begin
        trmt = 1'b0; trmt7 = 1'b0;
      end
      @(posedge clk); #1;
      rel = cyc - n0;
      tx_s   = d7 ? TX7      : TX;
      done_s = d7 ? tx_done7 : tx_done;
      busy_s = d7 ? busy7    : busy;
      ovr_s  = d7 ? tx_ovr7  : tx_ovr;
      full_s = d7 ? tx_full7 : tx_full;
      if (rel == 1) begin
        chk({tag, "_tx_before_start"}, tx_s, 1'b1);
        chk({tag, "_busy"}, busy_s, 1'b1);
      end
      if (rel >= 2) begin
        r = rel - 2;
        if (r % FB == 0 && r / FB < nfr)      chk({tag, "_start_edge"}, tx_s, 1'b0);
        if (r % FB == FB - 1 && r / FB < nfr) chk({tag, "_stop_tail"}, tx_s, 1'b1);
        if (r % BD == BD / 2 && idx < expq.size()) begin
          chk($sformatf("%s_bit%0d", tag, idx), tx_s, expq[idx]);
          idx++;
        end
      end
      if (done_s) begin
        if (nd < nfr) chk($sformatf("%s_done%0d_at", tag, nd), rel, exp_done[nd]);
        nd++;
      end
      if (ovr_s) begin
        chk({tag, "_ovr_at"}, rel, exp_ovr);
        nov++;
      end
      if (full_s && first_full < 0) first_full = rel;
    end
    trmt = 1'b0; trmt7 = 1'b0;
    chk({tag, "_bits_seen"}, idx, expq.size());
    chk({tag, "_done_count"}, nd, nfr);
    chk({tag, "_ovr_count"}, nov, (exp_ovr >= 0) ? 1 : 0);
    chk({tag, "_idle_after"}, d7 ? busy7 : busy, 1'b0);
  endtask

  initial begin
    int ff, n0, bad;
    vec_t v7;

    // exp[k] = line value in bit time k (k=0 start bit), hand-derived.
`ifdef UART_TX_PARITY_EN
    vt[0] = '{8'h6A, 1'b1, 11'b11011010100};  // odd parity -> 1
    vt[1] = '{8'h6A, 1'b0, 11'b10011010100};  // even parity -> 0
    vt[2] = '{8'h01, 1'b0, 11'b11000000010};
    vt[3] = '{8'h80, 1'b1, 11'b10100000000};
    vt[4] = '{8'hFF, 1'b0, 11'b10111111110};
    vt[5] = '{8'h00, 1'b1, 11'b11000000000};
    v7    = '{8'h55, 1'b0, 11'b11010101010};  // 7 data, parity 0, 2 stop
`else
    vt[0] = '{8'h6A, 1'b0, 11'b01011010100};
    vt[1] = '{8'h01, 1'b0, 11'b01000000010};
    vt[2] = '{8'h80, 1'b0, 11'b01100000000};
    vt[3] = '{8'hFF, 1'b0, 11'b01111111110};
    vt[4] = '{8'h00, 1'b0, 11'b01000000000};
    vt[5] = '{8'hA5, 1'b0, 11'b01101001010};
    v7    = '{8'h55, 1'b0, 11'b01110101010};  // 7 data, 2 stop
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", TX, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_ovr", tx_ovr, 1'b0);
    chk("rst_full", tx_full, 1'b0);
    chk("rst_tx7", TX7, 1'b1);
    chk("rst_busy7", busy7, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_tx", TX, 1'b1);

    // Single frames from the table
    for (int i = 0; i < 6; i++) begin
      clear_q();
      add_frame(vt[i], 1'b1);
      watch($sformatf("frame%0d", i), 1'b0, FB + 6, -1, ff);
      chk($sformatf("frame%0d_never_full", i), ff, -1);
    end

    // Burst of four back-to-back pushes: contiguous frames
    clear_q();
    for (int i = 1; i < 5; i++) add_frame(vt[i], 1'b1);
    watch("burst", 1'b0, 4 * FB + 6, -1, ff);
    chk("burst_never_full", ff, -1);

    // Overflow: six pushes, the sixth lands on a full FIFO and is dropped
    clear_q();
    for (int i = 0; i < 5; i++) add_frame(vt[i], 1'b1);
    add_frame(vt[5], 1'b0);
    watch("ovr", 1'b0, 5 * FB + 6, 5, ff);
    chk("ovr_full_at", ff, 4);

    // Reset in the middle of data bit 3, with a second byte queued
    clear_q();
    trmt = 1'b1; tx_data = 8'h6A; par_odd = 1'b0;
    @(posedge clk); #1;
    n0 = cyc;
    tx_data = 8'h55;
    @(posedge clk); #1;
    trmt = 1'b0;
    repeat (69) @(posedge clk);
    #1;
    chk("mid_rel", cyc - n0, 70);
    chk("mid_tx_bit3", TX, 1'b1);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_tx", TX, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_full", tx_full, 1'b0);
    chk("mrst_done", tx_done, 1'b0);
    rst = 1'b0;
    bad = 0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (TX !== 1'b1 || tx_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("mrst_queue_dropped", bad, 0);
    clear_q();
    add_frame(vt[5], 1'b1);
    watch("post_rst", 1'b0, FB + 6, -1, ff);

    // DATA_W=7, STOP_BITS=2 instance
    clear_q();
    add_frame(v7, 1'b1);
    watch("w7s2", 1'b1, FB + 6, -1, ff);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
